// File: rtl/rx_serial_7e1.sv
// rx_serial_7e1: 7E1 serial receiver with a 2-flop synchronizer, parity/stop
// checks, a one-cycle pronto pulse and sticky tem_dado / overrun flags.
// Ports: clock, reset (async, active low), dado_serial (line, idle high),
//   limpa (clears tem_dado and erro_sobreposicao), dados_ascii[6:0], pronto,
//   tem_dado, erro_paridade, erro_stop, erro_sobreposicao.
// Option: define RX_MAIORIA_EN to vote 2-of-3 around each sample point.
module rx_serial_7e1 #(
  parameter int CLKS_POR_BIT = 434,
  parameter int W_CONT       = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dado_serial,
  input  logic       limpa,
  output logic [6:0] dados_ascii,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro_paridade,
  output logic       erro_stop,
  output logic       erro_sobreposicao
);

  typedef enum logic [2:0] {
    ESPERA, INICIO, DADOS, PARIDADE,
    STOP, ARMAZENA, REPOUSO
  } estado_t;

`ifdef RX_MAIORIA_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif

  // The counter reads 0 in the cycle after t0, so the start sample
  // lands on cnt == half-1; later samples are one full period apart.
  localparam logic [W_CONT-1:0] PRIM =
    W_CONT'(CLKS_POR_BIT / 2 - 1 + OFS);
  localparam logic [W_CONT-1:0] PER =
    W_CONT'(CLKS_POR_BIT - 1);

  estado_t           state_q, state_d;
  logic              sync1_q, sync2_q;
  logic [W_CONT-1:0] cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [6:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              stop_q, stop_d;
  logic [6:0]        dados_q, dados_d;
  logic              tem_q, tem_d;
  logic              epar_q, epar_d;
  logic              estop_q, estop_d;
  logic              esob_q, esob_d;
  logic              linha;
  logic              bit_amostra;

  assign linha = sync2_q;

`ifdef RX_MAIORIA_EN
  logic hist1_q, hist2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
    end
  end

  // Evaluated at t+1: sync2 is t+1, hist1 is t, hist2 is t-1.
  assign bit_amostra = (sync2_q & hist1_q) |
                       (sync2_q & hist2_q) |
                       (hist1_q & hist2_q);
`else
  assign bit_amostra = linha;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ESPERA;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b1;
      dados_q <= '0;
      tem_q   <= 1'b0;
      epar_q  <= 1'b0;
      estop_q <= 1'b0;
      esob_q  <= 1'b0;
    end else begin
      sync1_q <= dado_serial;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      dados_q <= dados_d;
      tem_q   <= tem_d;
      epar_q  <= epar_d;
      estop_q <= estop_d;
      esob_q  <= esob_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + W_CONT'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    unique case (state_q)
      ESPERA: begin
        cnt_d = '0;
        idx_d = '0;
        if (!linha) state_d = INICIO;
      end
      INICIO: begin
        if (cnt_q == PRIM) begin
          cnt_d   = '0;
          state_d = bit_amostra ? ESPERA : DADOS;
        end
      end
      DADOS: begin
        if (cnt_q == PER) begin
          cnt_d   = '0;
          shift_d = {bit_amostra, shift_q[6:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd6) state_d = PARIDADE;
        end
      end
      PARIDADE: begin
        if (cnt_q == PER) begin
          cnt_d   = '0;
          par_d   = bit_amostra;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == PER) begin
          cnt_d   = '0;
          stop_d  = bit_amostra;
          state_d = ARMAZENA;
        end
      end
      ARMAZENA: begin
        cnt_d   = '0;
        state_d = stop_q ? ESPERA : REPOUSO;
      end
      REPOUSO: begin
        cnt_d = '0;
        if (linha) state_d = ESPERA;
      end
      default: begin
        cnt_d   = '0;
        state_d = ESPERA;
      end
    endcase
  end

  always_comb begin
    pronto  = (state_q == ARMAZENA);
    dados_d = dados_q;
    tem_d   = tem_q;
    epar_d  = epar_q;
    estop_d = estop_q;
    esob_d  = esob_q;
    if (pronto) begin
      dados_d = shift_q;
      epar_d  = (^shift_q) ^ par_q;
      estop_d = ~stop_q;
      tem_d   = 1'b1;
      // limpa in the same cycle still clears the overrun flag.
      esob_d  = limpa ? 1'b0 : (esob_q | tem_q);
    end else if (limpa) begin
      tem_d  = 1'b0;
      esob_d = 1'b0;
    end
  end

  assign dados_ascii       = dados_q;
  assign tem_dado          = tem_q;
  assign erro_paridade     = epar_q;
  assign erro_stop         = estop_q;
  assign erro_sobreposicao = esob_q;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// tb_rx_serial_7e1: scoreboard bench for rx_serial_7e1 (16 clocks/bit).
// Frames are queued when driven and checked when pronto fires.
module tb_rx_serial_7e1;

  localparam int C = 16;
`ifdef RX_MAIORIA_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  // drive-to-pronto: 2 sync cycles + 9.5 bits + 1 (+1 with voting)
  localparam int LAT = 2 + 9 * C + C / 2 + 1 + OFS;

  typedef struct {
    logic [6:0] d;
    logic       pe;
    logic       se;
    int         pcyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dado = 1'b1;
  logic       limpa = 1'b0;
  logic [6:0] dados_ascii;
  logic       pronto, tem_dado;
  logic       erro_paridade, erro_stop;
  logic       erro_sobreposicao;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [6:0] last_data = '0;

  logic m_tem = 1'b0;
  logic m_sob = 1'b0;

  rx_serial_7e1 #(.CLKS_POR_BIT(C), .W_CONT(5)) dut (
    .clock             (clk),
    .reset             (rst_n),
    .dado_serial       (dado),
    .limpa             (limpa),
    .dados_ascii       (dados_ascii),
    .pronto            (pronto),
    .tem_dado          (tem_dado),
    .erro_paridade     (erro_paridade),
    .erro_stop         (erro_stop),
    .erro_sobreposicao (erro_sobreposicao)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples at negedge; inputs seen here are what the
  // next posedge will capture.
  initial begin
    exp_t cur;
    bit   chk_next;
    bit   pend;
    logic ns;
    chk_next = 0;
    pend     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_tem    = 1'b0;
        m_sob    = 1'b0;
        chk_next = 0;
        pend     = 0;
        continue;
      end
      if (chk_next) begin
        check("tem_dado", tem_dado, m_tem);
        check("sobrepos", erro_sobreposicao, m_sob);
        if (pend) begin
          check("pronto_width", pronto, 1'b0);
          check("dados", dados_ascii, cur.d);
          check("erro_par", erro_paridade, cur.pe);
          check("erro_stop", erro_stop, cur.se);
        end
      end
      chk_next = 0;
      pend     = 0;
      if (pronto) begin
        if (sb.size() == 0) begin
          check("unexpected_pronto", 1, 0);
        end else begin
          cur = sb.pop_front();
          check("pronto_cycle", cyc, cur.pcyc);
          pend = 1;
        end
        ns    = limpa ? 1'b0 : (m_sob | m_tem);
        m_sob = ns;
        m_tem = 1'b1;
        chk_next = 1;
      end else if (limpa) begin
        m_tem    = 1'b0;
        m_sob    = 1'b0;
        chk_next = 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [6:0] d,
                            input logic par,
                            input logic stp,
                            input bit glitch);
    logic [9:0] b;
    exp_t e;
    b      = {stp, par, d, 1'b0};
    e.d    = d;
    e.pe   = (^d) ^ par;
    e.se   = ~stp;
    e.pcyc = cyc + LAT;
    sb.push_back(e);
    last_data = d;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < C; j++) begin
        dado = (glitch && j == C / 2) ? ~b[i] : b[i];
        tick(1);
      end
    end
    dado = 1'b1;
  endtask

  task automatic pulse_limpa();
    limpa = 1'b1;
    tick(1);
    limpa = 1'b0;
    tick(2);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    tick(3);
    #2;
    check("rst_dados", dados_ascii, 7'h00);
    check("rst_flags",
          {pronto, tem_dado, erro_paridade,
           erro_stop, erro_sobreposicao}, 5'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2 * C);

    // 'A', correct parity, latency checked by the monitor
    send_frame(7'h41, 1'b0, 1'b1, 0);
    tick(2 * C);

    // 0x43 with wrong parity
    pulse_limpa();
    send_frame(7'h43, 1'b0, 1'b1, 0);
    tick(2 * C);

    // short low pulse: rejected as a glitch
    dado = 1'b0;
    tick(3);
    dado = 1'b1;
    tick(3 * C);
    check("glitch_dados", dados_ascii, last_data);
    check("glitch_tem", tem_dado, m_tem);

    // framing error, break held, then a clean frame
    pulse_limpa();
    send_frame(7'h41, 1'b0, 1'b0, 0);
    dado = 1'b0;
    tick(3 * C);
    dado = 1'b1;
    tick(2 * C);
    pulse_limpa();
    send_frame(7'h55, 1'b0, 1'b1, 0);
    tick(2 * C);

    // overrun, clear, then limpa coincident with pronto
    pulse_limpa();
    send_frame(7'h41, 1'b0, 1'b1, 0);
    send_frame(7'h5A, 1'b0, 1'b1, 0);
    tick(2);
    check("overrun_data", dados_ascii, 7'h5A);
    check("overrun_flag", erro_sobreposicao, 1'b1);
    pulse_limpa();
    check("clr_tem", tem_dado, 1'b0);
    check("clr_sob", erro_sobreposicao, 1'b0);
    fork
      send_frame(7'h3C, 1'b0, 1'b1, 0);
      begin
        for (int k = 0; k < 400; k++) begin
          @(posedge clk);
          #1;
          if (pronto) break;
        end
        check("limpa_pronto_seen", pronto, 1'b1);
        limpa = 1'b1;
        tick(1);
        limpa = 1'b0;
      end
    join
    tick(2);
    check("set_wins_tem", tem_dado, 1'b1);

    // reset in the middle of the data bits
    begin
      logic [9:0] b;
      b = {1'b1, 1'b1, 7'h6B, 1'b0};
      for (int i = 0; i < 5; i++) begin
        dado = b[i];
        tick(C);
      end
      dado = b[5];
      tick(C / 2);
      rst_n = 1'b0;
      dado  = 1'b1;
      #1;
      check("arst_dados", dados_ascii, 7'h00);
      check("arst_flags",
            {pronto, tem_dado, erro_paridade,
             erro_stop, erro_sobreposicao}, 5'b0);
      tick(3);
      rst_n = 1'b1;
      tick(2 * C);
    end
    send_frame(7'h30, 1'b0, 1'b1, 0);
    tick(2 * C);

`ifdef RX_MAIORIA_EN
    pulse_limpa();
    send_frame(7'h2D, 1'b0, 1'b1, 1);
    tick(2 * C);
`endif

    tick(4 * C);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
